// File: rtl/branch_repair_ctrl_pkg.sv
// rtl/branch_repair_ctrl_pkg.sv - shared encodings for the branch repair controller
package branch_repair_ctrl_pkg;

  localparam int unsigned NEED_REPAIR  = 0;
  localparam int unsigned DSLOT_OFFSET = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_BR  = 2'd1,
    HOLD_EXC = 2'd2
  } state_e;

  typedef enum logic {
    SRC_FBA = 1'b0,
    SRC_SBA = 1'b1
  } src_e;

endpackage

// File: rtl/branch_upd_fifo.sv
// rtl/branch_upd_fifo.sv - synchronous FIFO for BPU training updates
module branch_upd_fifo #(
  parameter int unsigned DATA_W = 65,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit separates a wrapped (full) FIFO from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/branch_repair_ctrl.sv
// rtl/branch_repair_ctrl.sv - flush arbitration, fetch redirect hold and predictor repair
// Optional perf counters via REPAIR_PERF_CNT_EN.
module branch_repair_ctrl
  import branch_repair_ctrl_pkg::*;
#(
  parameter int unsigned VADDR_W   = 32,
  parameter int unsigned CKPT_W    = 16,
  parameter int unsigned RA_W      = 4,
  parameter int unsigned UPD_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sba_flush_i,
  input  logic [VADDR_W-1:0] sba_erro_vaddr_i,
  input  logic [VADDR_W-1:0] sba_corr_dest_i,
  input  logic               sba_corr_take_i,
  input  logic [CKPT_W-1:0]  sba_checkpoint_i,
  input  logic [RA_W-1:0]    sba_repair_action_i,
  input  logic               fba_flush_i,
  input  logic [VADDR_W-1:0] fba_erro_vaddr_i,
  input  logic [VADDR_W-1:0] fba_corr_dest_i,
  input  logic               fba_corr_take_i,
  input  logic [CKPT_W-1:0]  fba_checkpoint_i,
  input  logic [RA_W-1:0]    fba_repair_action_i,
  input  logic               cp0_exc_occur_i,
  input  logic [VADDR_W-1:0] cp0_exc_dest_i,
  output logic               redirect_valid_o,
  output logic [VADDR_W-1:0] redirect_pc_o,
  input  logic               redirect_ready_i,
  output logic               restore_valid_o,
  output logic [CKPT_W-1:0]  restore_checkpoint_o,
  output logic [RA_W-1:0]    restore_action_o,
  output logic               upd_valid_o,
  output logic [VADDR_W-1:0] upd_pc_o,
  output logic [VADDR_W-1:0] upd_dest_o,
  output logic               upd_take_o,
  input  logic               upd_ready_i,
  output logic               upd_full_o
`ifdef REPAIR_PERF_CNT_EN
  ,
  output logic [31:0]        sba_cnt_o,
  output logic [31:0]        fba_cnt_o,
  output logic [31:0]        drop_cnt_o
`endif
);

  localparam int unsigned UPD_W = 2*VADDR_W + 1;

  state_e             state;
  src_e               src;
  logic               sba_take;
  logic               fba_take;
  logic               hs;
  logic               free;
  logic               acc_sba;
  logic               acc_fba;
  logic               push;
  logic [UPD_W-1:0]   push_data;
  logic [UPD_W-1:0]   head;
  logic [VADDR_W-1:0] br_pc;
  logic [CKPT_W-1:0]  sel_ckpt;
  logic [RA_W-1:0]    sel_ra;
  logic               fifo_full;
  logic               fifo_empty;

  always_comb begin
    sba_take = sba_flush_i && sba_repair_action_i[NEED_REPAIR];
    fba_take = fba_flush_i && fba_repair_action_i[NEED_REPAIR];
    hs       = (state != IDLE) && redirect_ready_i;
    // A handshake cycle behaves like IDLE so back-to-back flushes see no bubble.
    free     = (state == IDLE) || hs;
    acc_sba  = !cp0_exc_occur_i && sba_take &&
               (free || (state == HOLD_BR && src == SRC_FBA));
    acc_fba  = !cp0_exc_occur_i && fba_take && free && !sba_take;
    push     = acc_sba || acc_fba;
    if (acc_sba) begin
      push_data = {sba_erro_vaddr_i, sba_corr_dest_i, sba_corr_take_i};
      br_pc     = sba_corr_take_i ? sba_corr_dest_i
                                  : sba_erro_vaddr_i + VADDR_W'(DSLOT_OFFSET);
      sel_ckpt  = sba_checkpoint_i;
      sel_ra    = sba_repair_action_i;
    end else begin
      push_data = {fba_erro_vaddr_i, fba_corr_dest_i, fba_corr_take_i};
      br_pc     = fba_corr_take_i ? fba_corr_dest_i
                                  : fba_erro_vaddr_i + VADDR_W'(DSLOT_OFFSET);
      sel_ckpt  = fba_checkpoint_i;
      sel_ra    = fba_repair_action_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      src                  <= SRC_FBA;
      redirect_valid_o     <= 1'b0;
      redirect_pc_o        <= '0;
      restore_valid_o      <= 1'b0;
      restore_checkpoint_o <= '0;
      restore_action_o     <= '0;
    end else begin
      restore_valid_o <= push;
      if (push) begin
        restore_checkpoint_o <= sel_ckpt;
        restore_action_o     <= sel_ra;
      end
      if (cp0_exc_occur_i) begin
        state            <= HOLD_EXC;
        redirect_valid_o <= 1'b1;
        redirect_pc_o    <= cp0_exc_dest_i;
      end else if (push) begin
        state            <= HOLD_BR;
        src              <= acc_sba ? SRC_SBA : SRC_FBA;
        redirect_valid_o <= 1'b1;
        redirect_pc_o    <= br_pc;
      end else if (hs) begin
        state            <= IDLE;
        redirect_valid_o <= 1'b0;
      end
    end
  end

  branch_upd_fifo #(
    .DATA_W (UPD_W),
    .DEPTH  (UPD_DEPTH)
  ) u_upd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (upd_ready_i),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign upd_valid_o = !fifo_empty;
  assign upd_full_o  = fifo_full;
  assign {upd_pc_o, upd_dest_o, upd_take_o} = head;

`ifdef REPAIR_PERF_CNT_EN
  logic drop;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign drop = push && fifo_full && !upd_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sba_cnt_o  <= '0;
      fba_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (acc_sba && sba_cnt_o != '1) sba_cnt_o <= sba_cnt_o + 32'd1;
      if (acc_fba && fba_cnt_o != '1) fba_cnt_o <= fba_cnt_o + 32'd1;
      if (drop && drop_cnt_o != '1)   drop_cnt_o <= drop_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_repair_ctrl.sv
// tb/tb_branch_repair_ctrl.sv - self-checking bench for branch_repair_ctrl
module tb_branch_repair_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sba_flush = 1'b0, fba_flush = 1'b0, cp0_occ = 1'b0;
  logic [31:0] sba_erro = '0, sba_dest = '0, fba_erro = '0, fba_dest = '0, cp0_dest = '0;
  logic        sba_take = 1'b0, fba_take = 1'b0;
  logic [15:0] sba_ckpt = '0, fba_ckpt = '0;
  logic [3:0]  sba_ra = '0, fba_ra = '0;
  logic        redirect_ready = 1'b0, upd_ready = 1'b0;
  logic        redirect_valid, restore_valid, upd_valid, upd_take, upd_full;
  logic [31:0] redirect_pc, upd_pc, upd_dest;
  logic [15:0] restore_ckpt;
  logic [3:0]  restore_action;
`ifdef REPAIR_PERF_CNT_EN
  logic [31:0] sba_cnt, fba_cnt, drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_repair_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .sba_flush_i          (sba_flush),
    .sba_erro_vaddr_i     (sba_erro),
    .sba_corr_dest_i      (sba_dest),
    .sba_corr_take_i      (sba_take),
    .sba_checkpoint_i     (sba_ckpt),
    .sba_repair_action_i  (sba_ra),
    .fba_flush_i          (fba_flush),
    .fba_erro_vaddr_i     (fba_erro),
    .fba_corr_dest_i      (fba_dest),
    .fba_corr_take_i      (fba_take),
    .fba_checkpoint_i     (fba_ckpt),
    .fba_repair_action_i  (fba_ra),
    .cp0_exc_occur_i      (cp0_occ),
    .cp0_exc_dest_i       (cp0_dest),
    .redirect_valid_o     (redirect_valid),
    .redirect_pc_o        (redirect_pc),
    .redirect_ready_i     (redirect_ready),
    .restore_valid_o      (restore_valid),
    .restore_checkpoint_o (restore_ckpt),
    .restore_action_o     (restore_action),
    .upd_valid_o          (upd_valid),
    .upd_pc_o             (upd_pc),
    .upd_dest_o           (upd_dest),
    .upd_take_o           (upd_take),
    .upd_ready_i          (upd_ready),
    .upd_full_o           (upd_full)
`ifdef REPAIR_PERF_CNT_EN
    ,
    .sba_cnt_o            (sba_cnt),
    .fba_cnt_o            (fba_cnt),
    .drop_cnt_o           (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending redirect slot plus a list of training entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] dest;
    logic        take;
  } upd_t;

  bit          m_pend = 0, m_exc = 0, m_from_sba = 0;
  logic [31:0] m_pc = '0;
  bit          m_rv = 0;
  logic [15:0] m_rc = '0;
  logic [3:0]  m_ra = '0;
  upd_t        q[$];
  int          m_sba = 0, m_fba = 0, m_drop = 0;
  bit          t_hs, t_free, t_s, t_f, t_pop, t_acc;
  upd_t        t_e;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = 0; m_exc = 0; m_from_sba = 0; m_pc = '0;
      m_rv = 0; m_rc = '0; m_ra = '0;
      q.delete();
      m_sba = 0; m_fba = 0; m_drop = 0;
    end else begin
      t_hs   = m_pend && redirect_ready;
      t_free = !m_pend || t_hs;
      t_s    = sba_flush && sba_ra[0];
      t_f    = fba_flush && fba_ra[0];
      t_pop  = upd_ready && q.size() > 0;
      t_acc  = 0;
      m_rv   = 0;
      if (cp0_occ) begin
        m_pend = 1; m_exc = 1; m_pc = cp0_dest;
      end else if (t_s && (t_free || (!m_exc && !m_from_sba))) begin
        t_acc = 1; m_sba++;
        m_pend = 1; m_exc = 0; m_from_sba = 1; m_rv = 1;
        m_pc = sba_take ? sba_dest : sba_erro + 32'd8;
        m_rc = sba_ckpt; m_ra = sba_ra;
        t_e = '{sba_erro, sba_dest, sba_take};
      end else if (t_f && t_free) begin
        t_acc = 1; m_fba++;
        m_pend = 1; m_exc = 0; m_from_sba = 0; m_rv = 1;
        m_pc = fba_take ? fba_dest : fba_erro + 32'd8;
        m_rc = fba_ckpt; m_ra = fba_ra;
        t_e = '{fba_erro, fba_dest, fba_take};
      end else if (t_hs) begin
        m_pend = 0;
      end
      if (t_pop) void'(q.pop_front());
      if (t_acc) begin
        if (q.size() < 4) q.push_back(t_e);
        else m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("redirect_valid", redirect_valid, m_pend);
      if (m_pend) chk("redirect_pc", redirect_pc, m_pc);
      chk("restore_valid", restore_valid, m_rv);
      if (m_rv) begin
        chk("restore_ckpt", restore_ckpt, m_rc);
        chk("restore_action", restore_action, m_ra);
      end
      chk("upd_valid", upd_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("upd_pc", upd_pc, q[0].pc);
        chk("upd_dest", upd_dest, q[0].dest);
        chk("upd_take", upd_take, q[0].take);
      end
      chk("upd_full", upd_full, q.size() == 4);
`ifdef REPAIR_PERF_CNT_EN
      chk("sba_cnt", sba_cnt, m_sba);
      chk("fba_cnt", fba_cnt, m_fba);
      chk("drop_cnt", drop_cnt, m_drop);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    sba_flush = 0; fba_flush = 0; cp0_occ = 0;
  endtask

  task automatic sba(input logic [31:0] e, input logic [31:0] d, input logic t,
                     input logic [15:0] c, input logic [3:0] a);
    sba_flush = 1; sba_erro = e; sba_dest = d; sba_take = t; sba_ckpt = c; sba_ra = a;
  endtask

  task automatic fba(input logic [31:0] e, input logic [31:0] d, input logic t,
                     input logic [15:0] c, input logic [3:0] a);
    fba_flush = 1; fba_erro = e; fba_dest = d; fba_take = t; fba_ckpt = c; fba_ra = a;
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_restore_valid", restore_valid, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_full", upd_full, 0);
    rst = 1;
    tick();

    // SBA taken, fetch ready
    redirect_ready = 1;
    sba(32'hBFC0_00F0, 32'hBFC0_0100, 1, 16'hA5A5, 4'b0001);
    tick(); clr();
    chk("t1_valid", redirect_valid, 1);
    chk("t1_pc", redirect_pc, 32'hBFC0_0100);
    chk("t1_restore", restore_valid, 1);
    chk("t1_ckpt", restore_ckpt, 16'hA5A5);
    tick();
    chk("t1_idle", redirect_valid, 0);
    chk("t1_restore_once", restore_valid, 0);
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_upd_pc", upd_pc, 32'hBFC0_00F0);
    chk("t1_upd_dest", upd_dest, 32'hBFC0_0100);
    upd_ready = 1;
    tick();
    upd_ready = 0;
    chk("t1_upd_popped", upd_valid, 0);

    // FBA not-taken held, then replaced by SBA
    redirect_ready = 0;
    fba(32'h8000_0010, 32'h1234_5678, 0, 16'h1111, 4'b0011);
    tick(); clr();
    chk("t2_pc", redirect_pc, 32'h8000_0018);
    chk("t2_model_pc", m_pc, 32'h8000_0018);
    tick();
    chk("t2_pc_held", redirect_pc, 32'h8000_0018);
    chk("t2_no_restore", restore_valid, 0);
    sba(32'h9000_0000, 32'h9000_0040, 1, 16'h2222, 4'b0101);
    tick(); clr();
    chk("t2_sba_pc", redirect_pc, 32'h9000_0040);
    chk("t2_restrobe", restore_valid, 1);
    chk("t2_ckpt", restore_ckpt, 16'h2222);
    fba(32'h7000_0000, 32'h7000_0100, 1, 16'h3333, 4'b0001);
    tick(); clr();
    chk("t2_fba_ignored", redirect_pc, 32'h9000_0040);
    sba(32'h6000_0000, 32'h6000_0100, 1, 16'h4444, 4'b0001);
    tick(); clr();
    chk("t2_sba_over_sba_ignored", redirect_pc, 32'h9000_0040);
    redirect_ready = 1;
    tick();
    redirect_ready = 0;

    // CP0 beats a concurrent SBA while an FBA redirect is pending
    fba(32'h8000_0100, 32'h8000_0200, 1, 16'h5555, 4'b0001);
    tick(); clr();
    cp0_occ = 1; cp0_dest = 32'hBFC0_0380;
    sba(32'h9100_0000, 32'h9100_0040, 1, 16'h6666, 4'b0001);
    tick(); clr();
    chk("t3_pc", redirect_pc, 32'hBFC0_0380);
    chk("t3_no_restore", restore_valid, 0);
    sba(32'h9200_0000, 32'h9200_0040, 1, 16'h7777, 4'b0001);
    tick(); clr();
    chk("t3_exc_ignores_sba", redirect_pc, 32'hBFC0_0380);
    cp0_occ = 1; cp0_dest = 32'hBFC0_0400;
    tick(); clr();
    chk("t3_cp0_overwrite", redirect_pc, 32'hBFC0_0400);
    redirect_ready = 1;
    tick();
    chk("t3_idle", redirect_valid, 0);
    upd_ready = 1;
    repeat (4) tick();
    upd_ready = 0;

    // Five back-to-back flushes into a stalled FIFO
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) sba(32'hA000_0000 + i*32'h100, 32'hC000_0000 + i, i[0], 16'(i), 4'b0001);
      else            fba(32'hA000_0000 + i*32'h100, 32'hC000_0000 + i, i[0], 16'(i), 4'b0001);
      tick(); clr();
    end
    chk("t4_full", upd_full, 1);
    chk("t4_head_pc", upd_pc, 32'hA000_0000);
    chk("t4_model_drop", m_drop, 1);
`ifdef REPAIR_PERF_CNT_EN
    chk("t4_drop_cnt", drop_cnt, 1);
`endif
    upd_ready = 1;
    tick();
    chk("t4_head_pc_2", upd_pc, 32'hA000_0100);
    sba(32'hAA00_0000, 32'hCC00_0000, 1, 16'h0F0F, 4'b0001);
    tick(); clr();
    repeat (6) tick();
    chk("t4_drained", upd_valid, 0);
    upd_ready = 0;

    // NEED_REPAIR clear: ignored
    sba(32'hD000_0000, 32'hD000_0100, 1, 16'h1234, 4'b1110);
    fba(32'hD100_0000, 32'hD100_0100, 1, 16'h1234, 4'b0010);
    tick(); clr();
    chk("t5_ignored", redirect_valid, 0);
    chk("t5_no_restore", restore_valid, 0);
    chk("t5_no_upd", upd_valid, 0);

    // Asynchronous reset while a branch redirect is pending
    redirect_ready = 0;
    sba(32'hE000_0000, 32'hE000_0100, 1, 16'hBEEF, 4'b0001);
    tick(); clr();
    chk("t6_pending", redirect_valid, 1);
    #2 rst = 0;
    #1;
    chk("t6_rst_valid", redirect_valid, 0);
    chk("t6_rst_pc", redirect_pc, 0);
    chk("t6_rst_restore", restore_valid, 0);
    chk("t6_rst_upd", upd_valid, 0);
    tick();
    rst = 1;
    repeat (3) tick();
    chk("t6_after", redirect_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
